c4_board_engine: RTL and testbench

Board datapath and responder for the turn-control state machine in the Connect-Four game. The block stores a 6x7 board and holds the stacking height of each column. It answers the controller's three command strobes: load a piece, check for a win around the last placed piece, and compare the board for full. It returns `move_ok`, `win`, `full` and a `check_done` handshake, and exports the board bitmaps to the VGA renderer.

---
 rtl/c4_board_engine_if.sv | 31 +++
 rtl/c4_board_engine.sv | 187 ++++++++++++++++++
 tb/tb_c4_board_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/c4_board_engine_if.sv
// Command/response bundle between the Connect-Four turn controller and the board engine.
//   master : controller side (drives col, player and the three command strobes)
//   slave  : board engine side (drives move_ok, busy, check_done, win, full and the bitmaps)
// Board bitmaps: cell (r,c) is bit r*COLS+c, row 0 at the bottom, column 0 leftmost.
interface c4_board_engine_if #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
);
  logic [2:0]           col;
  logic                 player;
  logic                 en_load;
  logic                 en_check;
  logic                 en_comp_board;
  logic                 move_ok;
  logic                 busy;
  logic                 check_done;
  logic                 win;
  logic                 full;
  logic [ROWS*COLS-1:0] board_p1;
  logic [ROWS*COLS-1:0] board_p2;

  modport master (
    output col, player, en_load, en_check, en_comp_board,
    input  move_ok, busy, check_done, win, full, board_p1, board_p2
  );

  modport slave (
    input  col, player, en_load, en_check, en_comp_board,
    output move_ok, busy, check_done, win, full, board_p1, board_p2
  );
endinterface

// File: rtl/c4_board_engine.sv
// Connect-Four board datapath and win/full responder.
// Stores both players' occupancy bitmaps and per-column stack heights, drops pieces on
// en_load, scans the four lines through the last placed piece on en_check (one cell per
// cycle, busy high while scanning, check_done pulsed afterwards) and latches full on
// en_comp_board.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : c4_board_engine_if slave modport (commands in, status and bitmaps out)
module c4_board_engine #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input logic              clk,
  input logic              rst,
  c4_board_engine_if.slave bus
);
  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned IW     = $clog2(CELLS);
  localparam logic [2:0]  ROWS_H = 3'(ROWS);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;
  typedef enum logic [1:0] {DirH, DirV, DirD, DirA} dir_e;

  logic [CELLS-1:0] board_p1_q, board_p2_q;
  logic [2:0]       height_q [COLS];
  logic [2:0]       last_row_q, last_col_q;
  logic             last_player_q, has_last_q;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic             sense_q, sense_d;   // 0: positive offsets, 1: negated offsets
  logic [1:0]       step_q, step_d;     // distance k = 1..3 from the last piece
  logic [2:0]       count_q, count_d;   // line length including the last piece
  logic             win_q, win_d;
  logic             full_q;

  logic [2:0]       height_sel;
  logic             col_valid, move_ok, load_fire, all_full;
  logic [IW-1:0]    load_idx, scan_idx;
  int               dr, dc, scan_r, scan_c;
  logic             in_bounds, hit;
  logic [CELLS-1:0] own_board;
  logic [2:0]       count_hit;

  // Selected column height; out-of-range columns read as invalid.
  always_comb begin
    height_sel = '0;
    col_valid  = 1'b0;
    for (int c = 0; c < int'(COLS); c++) begin
      if (bus.col == 3'(c)) begin
        height_sel = height_q[c];
        col_valid  = 1'b1;
      end
    end
  end

  assign move_ok   = col_valid && (height_sel < ROWS_H);
  assign load_fire = bus.en_load && move_ok && (state_q != StScan);
  assign load_idx  = IW'(int'(height_sel) * int'(COLS) + int'(bus.col));

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      if (height_q[c] != ROWS_H) all_full = 1'b0;
    end
  end

  // Cell under examination: last piece plus step * direction, sign flipped for the
  // negative sense.
  always_comb begin
    dr = 0;
    dc = 0;
    unique case (dir_q)
      DirH: begin dr = 0; dc = 1;  end
      DirV: begin dr = 1; dc = 0;  end
      DirD: begin dr = 1; dc = 1;  end
      DirA: begin dr = 1; dc = -1; end
      default: ;
    endcase
    if (sense_q) begin
      dr = -dr;
      dc = -dc;
    end
    scan_r    = int'(last_row_q) + int'(step_q) * dr;
    scan_c    = int'(last_col_q) + int'(step_q) * dc;
    in_bounds = (scan_r >= 0) && (scan_r < int'(ROWS)) &&
                (scan_c >= 0) && (scan_c < int'(COLS));
    scan_idx  = in_bounds ? IW'(scan_r * int'(COLS) + scan_c) : '0;
    own_board = last_player_q ? board_p2_q : board_p1_q;
    hit       = in_bounds && own_board[scan_idx];
    count_hit = hit ? count_q + 3'd1 : count_q;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    sense_d = sense_q;
    step_d  = step_q;
    count_d = count_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        // A simultaneous load takes priority; the check is dropped.
        if (bus.en_check && !bus.en_load) begin
          if (has_last_q) begin
            state_d = StScan;
            dir_d   = DirH;
            sense_d = 1'b0;
            step_d  = 2'd1;
            count_d = 3'd1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StScan: begin
        count_d = count_hit;
        if (hit && step_q != 2'd3) begin
          step_d = step_q + 2'd1;
        end else if (!sense_q) begin
          sense_d = 1'b1;
          step_d  = 2'd1;
        end else begin
          // Both senses of this direction done.
          sense_d = 1'b0;
          step_d  = 2'd1;
          if (count_hit >= 3'd4) begin
            win_d   = 1'b1;
            state_d = StDone;
          end else begin
            count_d = 3'd1;
            if (dir_q == DirA) state_d = StDone;
            else               dir_d   = dir_e'(dir_q + 2'd1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_p1_q    <= '0;
      board_p2_q    <= '0;
      for (int c = 0; c < int'(COLS); c++) height_q[c] <= '0;
      last_row_q    <= '0;
      last_col_q    <= '0;
      last_player_q <= 1'b0;
      has_last_q    <= 1'b0;
      state_q       <= StIdle;
      dir_q         <= DirH;
      sense_q       <= 1'b0;
      step_q        <= 2'd1;
      count_q       <= 3'd1;
      win_q         <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sense_q <= sense_d;
      step_q  <= step_d;
      count_q <= count_d;
      win_q   <= win_d;
      if (bus.en_comp_board) full_q <= all_full;
      if (load_fire) begin
        if (bus.player) board_p2_q[load_idx] <= 1'b1;
        else            board_p1_q[load_idx] <= 1'b1;
        for (int c = 0; c < int'(COLS); c++) begin
          if (bus.col == 3'(c)) height_q[c] <= height_q[c] + 3'd1;
        end
        last_row_q    <= height_sel;
        last_col_q    <= bus.col;
        last_player_q <= bus.player;
        has_last_q    <= 1'b1;
      end
    end
  end

  assign bus.move_ok    = move_ok;
  assign bus.busy       = (state_q == StScan);
  assign bus.check_done = (state_q == StDone);
  assign bus.win        = win_q;
  assign bus.full       = full_q;
  assign bus.board_p1   = board_p1_q;
  assign bus.board_p2   = board_p2_q;
endmodule

// File: tb/tb_c4_board_engine.sv
// Directed bench for c4_board_engine: reset, vertical/horizontal wins, isolated piece,
// column overflow, busy protection, reset mid-scan and a full no-win board.
module tb_c4_board_engine;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  logic [41:0] exp_p1, exp_p2;
  int          mh [7];

  c4_board_engine_if #(.ROWS(6), .COLS(7)) bus ();

  c4_board_engine #(.ROWS(6), .COLS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic [41:0] obs, input logic [41:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_model;
    exp_p1 = '0;
    exp_p2 = '0;
    for (int i = 0; i < 7; i++) mh[i] = 0;
  endtask

  task automatic do_load(input int c, input bit p);
    bus.col     = 3'(c);
    bus.player  = p;
    bus.en_load = 1'b1;
    if (c < 7 && mh[c] < 6) begin
      if (p) exp_p2 = exp_p2 | (42'd1 << (mh[c] * 7 + c));
      else   exp_p1 = exp_p1 | (42'd1 << (mh[c] * 7 + c));
      mh[c]++;
    end
    tick;
    bus.en_load = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    clear_model;
    tick;
  endtask

  // Strobe en_check, count busy cycles, then expect a single check_done pulse.
  task automatic run_check(input string tag, input int exp_k, input logic exp_win);
    int n = 0;
    bus.en_check = 1'b1;
    tick;
    bus.en_check = 1'b0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    chki({tag, " busy cycles"}, n, exp_k);
    chk1({tag, " check_done"}, bus.check_done, 1'b1);
    chk1({tag, " win"}, bus.win, exp_win);
    tick;
    chk1({tag, " check_done low"}, bus.check_done, 1'b0);
  endtask

  initial begin
    int nb, nd;
    rst               = 1'b1;
    bus.col           = '0;
    bus.player        = 1'b0;
    bus.en_load       = 1'b0;
    bus.en_check      = 1'b0;
    bus.en_comp_board = 1'b0;
    clear_model;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    // Post-reset state
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst check_done", bus.check_done, 1'b0);
    chk1("rst win", bus.win, 1'b0);
    chk1("rst full", bus.full, 1'b0);
    chkb("rst p1", bus.board_p1, 42'h0);
    chk1("rst move_ok col0", bus.move_ok, 1'b1);

    // Reset asserted mid-run clears a loaded piece asynchronously
    do_load(2, 1'b0);
    chkb("load p1 col2", bus.board_p1, 42'h4);
    rst = 1'b1;
    #1;
    chkb("async rst p1", bus.board_p1, 42'h0);
    chkb("async rst p2", bus.board_p2, 42'h0);
    chk1("async rst busy", bus.busy, 1'b0);
    chk1("async rst win", bus.win, 1'b0);
    bus.col = 3'd0;
    #1;
    chk1("rst move_ok col0 b", bus.move_ok, 1'b1);
    bus.col = 3'd7;
    #1;
    chk1("rst move_ok col7", bus.move_ok, 1'b0);
    rst = 1'b0;
    clear_model;
    bus.col = 3'd0;
    tick;

    // Check with no piece placed: check_done in the very next cycle
    run_check("nopiece", 0, 1'b0);

    // Vertical win in column 3
    repeat (4) do_load(3, 1'b0);
    chkb("vert p1", bus.board_p1, 42'h1020408);
    run_check("vert", 6, 1'b1);
    // Isolated P2 piece at (0,4): full 8-cell scan, win stays sticky
    do_load(4, 1'b1);
    run_check("sticky", 8, 1'b1);
    do_reset;

    // Horizontal win with a P1 piece interleaved at (1,0)
    do_load(0, 1'b1);
    run_check("iso", 8, 1'b0);
    do_load(0, 1'b0);
    do_load(1, 1'b1);
    do_load(3, 1'b1);
    do_load(2, 1'b1);
    chkb("horiz p1", bus.board_p1, 42'h80);
    chkb("horiz p2", bus.board_p2, 42'hF);
    run_check("horiz", 5, 1'b1);
    do_reset;

    // Column overflow
    for (int i = 0; i < 6; i++) do_load(0, 1'(i % 2));
    chkb("ovf p1", bus.board_p1, 42'h10004001);
    chkb("ovf p2", bus.board_p2, 42'h800200080);
    bus.col = 3'd0;
    #1;
    chk1("ovf move_ok", bus.move_ok, 1'b0);
    bus.player  = 1'b0;
    bus.en_load = 1'b1;
    tick;
    bus.en_load = 1'b0;
    chkb("ovf 7th p1", bus.board_p1, 42'h10004001);
    chkb("ovf 7th p2", bus.board_p2, 42'h800200080);
    chk1("ovf 7th move_ok", bus.move_ok, 1'b0);
    bus.col = 3'd1;
    #1;
    chk1("ovf col1 move_ok", bus.move_ok, 1'b1);

    // Busy protection: last piece (5,0) P2 is isolated in colour, K = 8
    nb = 0;
    nd = 0;
    bus.en_check = 1'b1;
    tick;
    bus.en_check = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) nb++;
      if (bus.check_done === 1'b1) nd++;
      if (i == 0) begin
        bus.col      = 3'd1;
        bus.player   = 1'b1;
        bus.en_load  = 1'b1;
        bus.en_check = 1'b1;
      end else begin
        bus.en_load  = 1'b0;
        bus.en_check = 1'b0;
      end
      tick;
    end
    chki("busy cycles", nb, 8);
    chki("busy done pulses", nd, 1);
    chkb("busy p1", bus.board_p1, 42'h10004001);
    chkb("busy p2", bus.board_p2, 42'h800200080);
    chk1("busy move_ok col1", bus.move_ok, 1'b1);
    chk1("busy win", bus.win, 1'b0);

    // Reset during a scan
    bus.en_check = 1'b1;
    tick;
    bus.en_check = 1'b0;
    tick;
    chk1("midscan busy before rst", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midscan rst busy", bus.busy, 1'b0);
    chk1("midscan rst check_done", bus.check_done, 1'b0);
    chkb("midscan rst p2", bus.board_p2, 42'h0);
    rst = 1'b0;
    clear_model;
    tick;

    // Full board in a no-win pattern: owner = (r/2 + c) % 2
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        if (!(r == 5 && c == 6)) do_load(c, 1'(((r / 2) + c) % 2));
      end
    end
    bus.col = 3'd6;
    #1;
    chk1("full41 move_ok col6", bus.move_ok, 1'b1);
    bus.en_comp_board = 1'b1;
    tick;
    bus.en_comp_board = 1'b0;
    chk1("full41", bus.full, 1'b0);
    do_load(6, 1'b0);
    chkb("full42 p1", bus.board_p1, exp_p1);
    chkb("full42 p2", bus.board_p2, exp_p2);
    chkb("full42 union", bus.board_p1 | bus.board_p2, 42'h3FFFFFFFFFF);
    chk1("full42 before compare", bus.full, 1'b0);
    bus.en_comp_board = 1'b1;
    tick;
    bus.en_comp_board = 1'b0;
    chk1("full42", bus.full, 1'b1);
    tick;
    chk1("full42 hold", bus.full, 1'b1);
    chk1("full42 win", bus.win, 1'b0);
    bus.col = 3'd6;
    #1;
    chk1("full42 move_ok col6", bus.move_ok, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
